// File: rtl/riplcry_add_4_1_str.sv
// 4-bit structural ripple-carry adder with a registered sum/carry stage.
// Optional macro RIPLCRY_OVF_EN adds a registered two's-complement overflow flag V.

module riplcry_fa (
  input  wire a,
  input  wire b,
  input  wire ci,
  output wire s,
  output wire co
);

  wire axb;
  wire ab;
  wire cxp;

  xor g_axb (axb, a, b);
  xor g_sum (s, axb, ci);
  and g_gen (ab, a, b);
  and g_prp (cxp, ci, axb);
  or  g_co  (co, ab, cxp);

endmodule

module riplcry_add_4_1_str (
  input  logic clk,
  input  logic rst,
  input  logic A3,
  input  logic A2,
  input  logic A1,
  input  logic A0,
  input  logic B3,
  input  logic B2,
  input  logic B1,
  input  logic B0,
  input  logic Cin,
  output logic Cout,
`ifdef RIPLCRY_OVF_EN
  output logic V,
`endif
  output logic S3,
  output logic S2,
  output logic S1,
  output logic S0
);

  localparam int unsigned W = 4;

  wire [W-1:0] a;
  wire [W-1:0] b;
  wire [W-1:0] s;
  wire [W:0]   c;

  assign a    = {A3, A2, A1, A0};
  assign b    = {B3, B2, B1, B0};
  assign c[0] = Cin;

  // Carry ripples LSB to MSB through one full adder per bit.
  for (genvar i = 0; i < W; i++) begin : g_bit
    riplcry_fa u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  // Output register; reset wins over incoming data.
  always_ff @(posedge clk) begin
    if (rst) begin
      Cout <= 1'b0;
      {S3, S2, S1, S0} <= '0;
    end else begin
      Cout <= c[W];
      {S3, S2, S1, S0} <= s;
    end
  end

`ifdef RIPLCRY_OVF_EN
  // Signed overflow: carry into MSB differs from carry out of MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      V <= 1'b0;
    end else begin
      V <= c[W-1] ^ c[W];
    end
  end
`endif

endmodule

// File: tb/tb_riplcry_add_4_1_str.sv
// Self-checking bench for riplcry_add_4_1_str; expected results queued at drive time.
// Build with RIPLCRY_OVF_EN to also check the overflow flag V.

module tb_riplcry_add_4_1_str;

  logic clk = 1'b0;
  logic rst;
  logic A3, A2, A1, A0;
  logic B3, B2, B1, B0;
  logic Cin;
  logic Cout;
  logic S3, S2, S1, S0;
`ifdef RIPLCRY_OVF_EN
  logic V;
`endif

  int tests  = 0;
  int failed = 0;

  logic [5:0] exp_q[$];
  string      tag_q[$];

  riplcry_add_4_1_str dut (
    .clk  (clk),
    .rst  (rst),
    .A3   (A3),
    .A2   (A2),
    .A1   (A1),
    .A0   (A0),
    .B3   (B3),
    .B2   (B2),
    .B1   (B1),
    .B0   (B0),
    .Cin  (Cin),
    .Cout (Cout),
`ifdef RIPLCRY_OVF_EN
    .V    (V),
`endif
    .S3   (S3),
    .S2   (S2),
    .S1   (S1),
    .S0   (S0)
  );

  always #5 clk = ~clk;

  // Reference: {v, cout, s[3:0]} from plain integer arithmetic.
  function automatic logic [5:0] model(input logic [3:0] a, input logic [3:0] b,
                                       input logic ci, input logic r);
    logic [4:0] sum;
    logic [3:0] low;
    logic       v;
    if (r) return 6'd0;
    sum = 5'({1'b0, a}) + 5'({1'b0, b}) + 5'(ci);
    low = 4'({1'b0, a[2:0]}) + 4'({1'b0, b[2:0]}) + 4'(ci);
`ifdef RIPLCRY_OVF_EN
    v = low[3] ^ sum[4];
`else
    v = 1'b0;
`endif
    return {v, sum};
  endfunction

  function automatic logic [5:0] observed();
    logic v;
`ifdef RIPLCRY_OVF_EN
    v = V;
`else
    v = 1'b0;
`endif
    return {v, Cout, S3, S2, S1, S0};
  endfunction

  task automatic check();
    logic [5:0] exp;
    logic [5:0] obs;
    string      tag;
    tests++;
    obs = observed();
    if (exp_q.size() == 0) begin
      failed++;
      $display("FAIL scoreboard_empty: observed %b expected a queued result", obs);
    end else begin
      exp = exp_q.pop_front();
      tag = tag_q.pop_front();
      assert (obs === exp) else begin
        failed++;
        $error("FAIL %s: observed {V,Cout,S}=%b expected %b", tag, obs, exp);
      end
    end
  endtask

  // Drive one operand set between edges, then check the result one edge later.
  task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic ci,
                       input logic r, input string tag);
    @(negedge clk);
    {A3, A2, A1, A0} = a;
    {B3, B2, B1, B0} = b;
    Cin = ci;
    rst = r;
    exp_q.push_back(model(a, b, ci, r));
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    check();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ra;
    logic [3:0] rb;
    logic       rc;
    rst = 1'b1;
    {A3, A2, A1, A0} = 4'h0;
    {B3, B2, B1, B0} = 4'h0;
    Cin = 1'b0;

    apply(4'hA, 4'h7, 1'b1, 1'b1, "reset_0");
    apply(4'hF, 4'hF, 1'b1, 1'b1, "reset_1");

    apply(4'b0011, 4'b0100, 1'b0, 1'b0, "add_3_4");
    apply(4'b0010, 4'b0110, 1'b0, 1'b0, "add_2_6_ovf");
    apply(4'b0110, 4'b1000, 1'b0, 1'b0, "add_6_8");
    apply(4'b1111, 4'b1111, 1'b1, 1'b0, "add_f_f_c");
    apply(4'b1111, 4'b0000, 1'b1, 1'b0, "full_ripple");
    apply(4'b0000, 4'b0000, 1'b0, 1'b0, "zero");
    apply(4'b0111, 4'b0001, 1'b0, 1'b0, "pos_ovf");
    apply(4'b1000, 4'b1000, 1'b0, 1'b0, "neg_ovf");

    apply(4'h1, 4'h2, 1'b0, 1'b0, "b2b_0");
    apply(4'h9, 4'h9, 1'b1, 1'b0, "b2b_1");
    apply(4'hE, 4'h5, 1'b1, 1'b1, "b2b_rst");
    apply(4'h5, 4'h6, 1'b0, 1'b0, "b2b_resume");
    apply(4'hC, 4'h3, 1'b1, 1'b0, "b2b_after");

    for (int i = 0; i < 24; i++) begin
      ra = 4'($urandom_range(15, 0));
      rb = 4'($urandom_range(15, 0));
      rc = 1'($urandom_range(1, 0));
      apply(ra, rb, rc, 1'b0, "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/riplcry_add_4_1_str.md
Name: riplcry_add_4_1_str

Overview:
- 4-bit ripple-carry adder built structurally from four chained 1-bit full adders using gate primitives: AND, OR, XOR.
- Sum and carry-out are captured in an output register stage.
- Used as a leaf arithmetic block wherever a small registered adder with bit-level ports is needed.

Parameters:
- None. Width fixed at 4 bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- A3  input  1  operand A bit 3 (MSB)
- A2  input  1  operand A bit 2
- A1  input  1  operand A bit 1
- A0  input  1  operand A bit 0 (LSB)
- B3  input  1  operand B bit 3 (MSB)
- B2  input  1  operand B bit 2
- B1  input  1  operand B bit 1
- B0  input  1  operand B bit 0 (LSB)
- Cin  input  1  carry into bit 0
- Cout  output  1  registered carry out of bit 3
- S3  output  1  registered sum bit 3 (MSB)
- S2  output  1  registered sum bit 2
- S1  output  1  registered sum bit 1
- S0  output  1  registered sum bit 0 (LSB)

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Combinational datapath:
  - Bit i full adder: s_i = A_i ^ B_i ^ c_i; c_(i+1) = (A_i & B_i) | (c_i & (A_i ^ B_i)).
  - c_0 = Cin. Internal carries c1..c3 ripple LSB to MSB. c4 is the carry-out.
- Full adder is its own structural submodule, instantiated 4 times. No behavioural "+" in the datapath.
- Arithmetic: {c4, s3..s0} = {A3..A0} + {B3..B0} + Cin. Unsigned, 5-bit result range 0..31.
- Register stage: on each rising clk edge with rst=0, {Cout,S3,S2,S1,S0} <= {c4,s3,s2,s1,s0}.
- Latency: exactly 1 clock from input change to output update. A new input can be accepted every cycle. No handshake.
- Reset: rst=1 at a rising edge forces Cout=0 and S3..S0=0 at that edge.
  - Reset has priority over new data.
  - Asserting reset mid-stream discards the in-flight result.
  - The first non-reset edge after deassertion registers the current inputs.
- Before the first clock edge, outputs are X (no initial values).
- X/Z on inputs propagate through the registers; no sanitising.
- Wrap-around: when the sum is ≥16, S3..S0 hold the sum modulo 16 and Cout=1. Example: 15+15+1 gives S=0xF, Cout=1.

Optional Feature:
- Macro: RIPLCRY_OVF_EN.
- Defined:
  - Adds output port V (1 bit, listed after Cout).
  - V is the registered two's-complement overflow flag: V <= c3 ^ c4.
  - Same 1-cycle latency as the sum; reset value 0.
- Not defined:
  - Port V and its logic are absent.
  - Port list is exactly as above.

Test Plan:
- rst=1 for 2 cycles with arbitrary inputs -> S3..S0=0000, Cout=0. Then release rst.
- A=0011, B=0100, Cin=0 -> one cycle later S=0111 (7), Cout=0.
- A=0010, B=0110, Cin=0 -> S=1000 (8), Cout=0. With RIPLCRY_OVF_EN: V=1.
- A=0110, B=1000, Cin=0 -> S=1110 (14), Cout=0, V=0.
- A=1111, B=1111, Cin=1 -> S=1111, Cout=1. Then A=1111, B=0000, Cin=1 -> S=0000, Cout=1 (full ripple chain exercised).
- Back-to-back operands on consecutive cycles, with rst asserted on the third cycle:
  - Each result appears exactly 1 cycle after its inputs.
  - Outputs are 0 on the edge after rst is asserted.
  - Normal operation resumes on the first edge after rst is deasserted.
